// File: rtl/issue_decoder_pkg.sv
// Shared decode definitions for the issue stage.
// Opcode constants, op-class enum and decoded field widths.
package issue_decoder_pkg;

    localparam int INST_W = 32;
    localparam int REG_W  = 5;
    localparam int F3_W   = 3;
    localparam int CLS_W  = 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [CLS_W-1:0] {
        CLS_LUI     = 4'd0,
        CLS_AUIPC   = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JALR    = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_OPIMM   = 4'd7,
        CLS_OP      = 4'd8,
        CLS_ILLEGAL = 4'd9
    } op_class_e;

    function automatic logic is_mem(input op_class_e c);
        return (c == CLS_LOAD) || (c == CLS_STORE);
    endfunction

endpackage

// File: rtl/issue_decoder_rv32i_decode.sv
// Pure combinational RV32I field decoder.
// Ports: inst in; cls/rd/rs1/rs2/imm/funct3/f7b5 out.
module rv32i_decode
    import issue_decoder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INST_W-1:0] inst,
    output op_class_e         cls,
    output logic [REG_W-1:0]  rd,
    output logic [REG_W-1:0]  rs1,
    output logic [REG_W-1:0]  rs2,
    output logic [XLEN-1:0]   imm,
    output logic [F3_W-1:0]   funct3,
    output logic              f7b5
);

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_sh;
    logic            is_shift;

    assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s  = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{(XLEN-12){inst[31]}}, inst[7],
                     inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
    assign imm_j  = {{(XLEN-20){inst[31]}}, inst[19:12],
                     inst[20], inst[30:21], 1'b0};
    assign imm_sh = {{(XLEN-5){1'b0}}, inst[24:20]};

    // slli/srli/srai carry a shamt, not a signed immediate
    assign is_shift = (inst[13:12] == 2'b01);

    assign funct3 = inst[14:12];
    assign f7b5   = inst[30];

    always_comb begin
        cls = CLS_ILLEGAL;
        rd  = '0;
        rs1 = '0;
        rs2 = '0;
        imm = '0;
        unique case (inst[6:0])
            OPC_LUI: begin
                cls = CLS_LUI;
                rd  = inst[11:7];
                imm = imm_u;
            end
            OPC_AUIPC: begin
                cls = CLS_AUIPC;
                rd  = inst[11:7];
                imm = imm_u;
            end
            OPC_JAL: begin
                cls = CLS_JAL;
                rd  = inst[11:7];
                imm = imm_j;
            end
            OPC_JALR: begin
                cls = CLS_JALR;
                rd  = inst[11:7];
                rs1 = inst[19:15];
                imm = imm_i;
            end
            OPC_BRANCH: begin
                cls = CLS_BRANCH;
                rs1 = inst[19:15];
                rs2 = inst[24:20];
                imm = imm_b;
            end
            OPC_LOAD: begin
                cls = CLS_LOAD;
                rd  = inst[11:7];
                rs1 = inst[19:15];
                imm = imm_i;
            end
            OPC_STORE: begin
                cls = CLS_STORE;
                rs1 = inst[19:15];
                rs2 = inst[24:20];
                imm = imm_s;
            end
            OPC_OPIMM: begin
                cls = CLS_OPIMM;
                rd  = inst[11:7];
                rs1 = inst[19:15];
                imm = is_shift ? imm_sh : imm_i;
            end
            OPC_OP: begin
                cls = CLS_OP;
                rd  = inst[11:7];
                rs1 = inst[19:15];
                rs2 = inst[24:20];
            end
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/issue_decoder.sv
// Issue stage: pops the fetch queue into a one-entry decode register
// and dispatches it to ROB+RS or ROB+LSB; counts dispatched instrs.
module issue_decoder
    import issue_decoder_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              fq_empty,
    input  logic [INST_W-1:0] fq_inst,
    input  logic [XLEN-1:0]   fq_pc,
    output logic              fq_re,
    input  logic              rob_full,
    input  logic              rs_full,
    input  logic              lsb_full,
    output logic              disp_o,
    output logic              disp_to_lsb_o,
    output logic [CLS_W-1:0]  disp_class_o,
    output logic [XLEN-1:0]   disp_pc_o,
    output logic [REG_W-1:0]  disp_rd_o,
    output logic [REG_W-1:0]  disp_rs1_o,
    output logic [REG_W-1:0]  disp_rs2_o,
    output logic [XLEN-1:0]   disp_imm_o,
    output logic [F3_W-1:0]   disp_funct3_o,
    output logic              disp_f7b5_o,
    output logic [CNT_W-1:0]  issued_cnt_o
);

    op_class_e        dec_cls;
    logic [REG_W-1:0] dec_rd;
    logic [REG_W-1:0] dec_rs1;
    logic [REG_W-1:0] dec_rs2;
    logic [XLEN-1:0]  dec_imm;
    logic [F3_W-1:0]  dec_funct3;
    logic             dec_f7b5;

    rv32i_decode #(.XLEN(XLEN)) u_dec (
        .inst   (fq_inst),
        .cls    (dec_cls),
        .rd     (dec_rd),
        .rs1    (dec_rs1),
        .rs2    (dec_rs2),
        .imm    (dec_imm),
        .funct3 (dec_funct3),
        .f7b5   (dec_f7b5)
    );

    logic      dvalid;
    op_class_e dcls;
    logic      need_lsb;
    logic      res_ok;

    assign need_lsb = is_mem(dcls);
    assign res_ok   = !rob_full &&
                      (need_lsb ? !lsb_full : !rs_full);

    assign disp_o        = dvalid && res_ok && !flush;
    assign disp_to_lsb_o = need_lsb;
    assign disp_class_o  = dcls;

    // Gated by rst so nothing is popped while reset is held.
    assign fq_re = rst && !fq_empty && !flush &&
                   (!dvalid || disp_o);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvalid        <= 1'b0;
            dcls          <= CLS_LUI;
            disp_pc_o     <= '0;
            disp_rd_o     <= '0;
            disp_rs1_o    <= '0;
            disp_rs2_o    <= '0;
            disp_imm_o    <= '0;
            disp_funct3_o <= '0;
            disp_f7b5_o   <= 1'b0;
        end else if (flush) begin
            dvalid <= 1'b0;
        end else if (fq_re) begin
            dvalid        <= 1'b1;
            dcls          <= dec_cls;
            disp_pc_o     <= fq_pc;
            disp_rd_o     <= dec_rd;
            disp_rs1_o    <= dec_rs1;
            disp_rs2_o    <= dec_rs2;
            disp_imm_o    <= dec_imm;
            disp_funct3_o <= dec_funct3;
            disp_f7b5_o   <= dec_f7b5;
        end else if (disp_o) begin
            dvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_cnt_o <= '0;
        end else if (disp_o) begin
            issued_cnt_o <= issued_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_issue_decoder.sv
// Self-checking bench for issue_decoder: directed scenarios then
// randomized traffic against a queue-based reference model.
module tb_issue_decoder;
    import issue_decoder_pkg::*;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        fq_empty;
    logic [31:0] fq_inst;
    logic [31:0] fq_pc;
    logic        fq_re;
    logic        rob_full;
    logic        rs_full;
    logic        lsb_full;
    logic        disp_o;
    logic        disp_to_lsb_o;
    logic [3:0]  disp_class_o;
    logic [31:0] disp_pc_o;
    logic [4:0]  disp_rd_o;
    logic [4:0]  disp_rs1_o;
    logic [4:0]  disp_rs2_o;
    logic [31:0] disp_imm_o;
    logic [2:0]  disp_funct3_o;
    logic        disp_f7b5_o;
    logic [CW-1:0] issued_cnt_o;

    always #5 clk = ~clk;

    issue_decoder #(.XLEN(32), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .fq_empty      (fq_empty),
        .fq_inst       (fq_inst),
        .fq_pc         (fq_pc),
        .fq_re         (fq_re),
        .rob_full      (rob_full),
        .rs_full       (rs_full),
        .lsb_full      (lsb_full),
        .disp_o        (disp_o),
        .disp_to_lsb_o (disp_to_lsb_o),
        .disp_class_o  (disp_class_o),
        .disp_pc_o     (disp_pc_o),
        .disp_rd_o     (disp_rd_o),
        .disp_rs1_o    (disp_rs1_o),
        .disp_rs2_o    (disp_rs2_o),
        .disp_imm_o    (disp_imm_o),
        .disp_funct3_o (disp_funct3_o),
        .disp_f7b5_o   (disp_f7b5_o),
        .issued_cnt_o  (issued_cnt_o)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fe_t;

    typedef struct packed {
        logic [3:0]  cls;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        f7b5;
    } pkt_t;

    fe_t     q[$];
    pkt_t    m_pkt;
    logic    m_dvalid;
    logic [CW-1:0] m_cnt;
    logic    e_disp;
    logic    e_re;
    int      errors = 0;
    int      checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the ISA field layout
    function automatic pkt_t ref_decode(input fe_t f);
        pkt_t p;
        logic [31:0] i;
        int s;
        i = f.inst;
        p = '0;
        p.pc = f.pc;
        p.f3 = i[14:12];
        p.f7b5 = i[30];
        case (i[6:0])
            7'h37, 7'h17: begin
                p.cls = (i[6:0] == 7'h37) ? 4'(CLS_LUI) : 4'(CLS_AUIPC);
                p.rd = i[11:7];
                p.imm = i & 32'hFFFFF000;
            end
            7'h6F: begin
                p.cls = 4'(CLS_JAL);
                p.rd = i[11:7];
                s = int'(i[30:21]) * 2 + int'(i[20]) * 2048
                  + int'(i[19:12]) * 4096 - int'(i[31]) * (1 << 20);
                p.imm = 32'(s);
            end
            7'h67, 7'h03, 7'h13: begin
                p.cls = (i[6:0] == 7'h67) ? 4'(CLS_JALR) :
                        (i[6:0] == 7'h03) ? 4'(CLS_LOAD) : 4'(CLS_OPIMM);
                p.rd = i[11:7];
                p.rs1 = i[19:15];
                s = int'(i[30:20]) - int'(i[31]) * 2048;
                p.imm = 32'(s);
                if (i[6:0] == 7'h13 && (p.f3 == 3'd1 || p.f3 == 3'd5))
                    p.imm = 32'(i[24:20]);
            end
            7'h63: begin
                p.cls = 4'(CLS_BRANCH);
                p.rs1 = i[19:15];
                p.rs2 = i[24:20];
                s = int'(i[11:8]) * 2 + int'(i[30:25]) * 32
                  + int'(i[7]) * 2048 - int'(i[31]) * 4096;
                p.imm = 32'(s);
            end
            7'h23: begin
                p.cls = 4'(CLS_STORE);
                p.rs1 = i[19:15];
                p.rs2 = i[24:20];
                s = int'(i[11:7]) + int'(i[30:25]) * 32
                  - int'(i[31]) * 2048;
                p.imm = 32'(s);
            end
            7'h33: begin
                p.cls = 4'(CLS_OP);
                p.rd = i[11:7];
                p.rs1 = i[19:15];
                p.rs2 = i[24:20];
            end
            default: p.cls = 4'(CLS_ILLEGAL);
        endcase
        return p;
    endfunction

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        fe_t f;
        f.inst = inst;
        f.pc = pc;
        q.push_back(f);
    endtask

    task automatic settle();
        logic mem;
        logic ok;
        fq_empty = (q.size() == 0);
        if (!fq_empty) begin
            fq_inst = q[0].inst;
            fq_pc = q[0].pc;
        end else begin
            fq_inst = $urandom;
            fq_pc = $urandom;
        end
        #1;
        mem = (m_pkt.cls == 4'(CLS_LOAD)) || (m_pkt.cls == 4'(CLS_STORE));
        ok = !rob_full && (mem ? !lsb_full : !rs_full);
        e_disp = rst && m_dvalid && ok && !flush;
        e_re = rst && !fq_empty && !flush && (!m_dvalid || e_disp);
        chk("disp_o", 32'(disp_o), 32'(e_disp));
        chk("fq_re", 32'(fq_re), 32'(e_re));
        chk("cnt", 32'(issued_cnt_o), 32'(m_cnt));
        chk("class", 32'(disp_class_o), 32'(m_pkt.cls));
        chk("pc", disp_pc_o, m_pkt.pc);
        chk("rd", 32'(disp_rd_o), 32'(m_pkt.rd));
        chk("rs1", 32'(disp_rs1_o), 32'(m_pkt.rs1));
        chk("rs2", 32'(disp_rs2_o), 32'(m_pkt.rs2));
        chk("imm", disp_imm_o, m_pkt.imm);
        chk("funct3", 32'(disp_funct3_o), 32'(m_pkt.f3));
        chk("f7b5", 32'(disp_f7b5_o), 32'(m_pkt.f7b5));
        if (e_disp)
            chk("to_lsb", 32'(disp_to_lsb_o), 32'(mem));
    endtask

    task automatic tick();
        if (rst) begin
            if (flush) begin
                m_dvalid = 1'b0;
            end else begin
                if (e_disp)
                    m_cnt = m_cnt + 1'b1;
                if (e_re) begin
                    m_pkt = ref_decode(q.pop_front());
                    m_dvalid = 1'b1;
                end else if (e_disp) begin
                    m_dvalid = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        m_dvalid = 1'b0;
        m_pkt = '0;
        m_cnt = '0;
    endtask

    initial begin
        logic [6:0] ops [10];
        logic [31:0] r;
        logic [31:0] saved;
        int n;
        int guard;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
        flush = 0;
        rob_full = 0;
        rs_full = 0;
        lsb_full = 0;
        fq_inst = '0;
        fq_pc = '0;
        fq_empty = 1;
        apply_reset();

        // reset held with a non-empty queue
        push(32'h00500093, 32'h0);
        push(32'h00102223, 32'h4);
        @(posedge clk);
        #1;
        settle();
        chk("rst_fq_re", 32'(fq_re), 0);
        chk("rst_disp", 32'(disp_o), 0);
        chk("rst_cnt", 32'(issued_cnt_o), 0);
        tick();
        rst = 1'b1;
        settle();
        chk("first_pop", 32'(fq_re), 1);
        tick();

        // back-to-back stream
        settle();
        chk("s1_disp", 32'(disp_o), 1);
        chk("s1_cls", 32'(disp_class_o), 32'(CLS_OPIMM));
        chk("s1_rd", 32'(disp_rd_o), 1);
        chk("s1_imm", disp_imm_o, 5);
        chk("s1_lsb", 32'(disp_to_lsb_o), 0);
        tick();
        settle();
        chk("s2_disp", 32'(disp_o), 1);
        chk("s2_cls", 32'(disp_class_o), 32'(CLS_STORE));
        chk("s2_rd", 32'(disp_rd_o), 0);
        chk("s2_rs2", 32'(disp_rs2_o), 1);
        chk("s2_imm", disp_imm_o, 4);
        chk("s2_lsb", 32'(disp_to_lsb_o), 1);
        tick();

        // backpressure on an lw; rs_full must not matter
        push(32'h0040a103, 32'h8);
        cycle();
        rs_full = 1;
        lsb_full = 1;
        push(32'h00500093, 32'hC);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("bp_disp", 32'(disp_o), 0);
            chk("bp_re", 32'(fq_re), 0);
            chk("bp_imm", disp_imm_o, 4);
            tick();
        end
        lsb_full = 0;
        settle();
        chk("bp_rel_disp", 32'(disp_o), 1);
        chk("bp_rel_re", 32'(fq_re), 1);
        tick();
        rs_full = 0;

        // flush with D-reg valid and queue non-empty
        push(32'h00102223, 32'h10);
        saved = 32'(issued_cnt_o);
        flush = 1;
        settle();
        chk("fl_disp", 32'(disp_o), 0);
        chk("fl_re", 32'(fq_re), 0);
        tick();
        flush = 0;
        settle();
        chk("fl_after_disp", 32'(disp_o), 0);
        chk("fl_cnt", 32'(issued_cnt_o), saved);
        tick();
        cycle();
        cycle();

        // immediate corner cases
        push(32'hfe000ce3, 32'h100);
        push(32'h801FF0EF, 32'h104);
        push(32'hFFFFF2B7, 32'h108);
        push(32'h4071D193, 32'h10C);
        push(32'h0000007F, 32'h110);
        guard = 0;
        while ((q.size() != 0 || m_dvalid) && guard < 20) begin
            settle();
            if (e_disp) begin
                case (m_pkt.pc)
                    32'h100: chk("beq_imm", disp_imm_o, 32'hFFFFFFF8);
                    32'h104: chk("jal_imm", disp_imm_o, 32'hFFFFF800);
                    32'h108: chk("lui_imm", disp_imm_o, 32'hFFFFF000);
                    32'h10C: begin
                        chk("srai_imm", disp_imm_o, 7);
                        chk("srai_f7b5", 32'(disp_f7b5_o), 1);
                    end
                    32'h110: chk("ill_cls", 32'(disp_class_o),
                                 32'(CLS_ILLEGAL));
                    default: ;
                endcase
            end
            tick();
            guard++;
        end
        chk("imm_drain_timeout", 32'(guard < 20), 1);

        // async reset mid-stall
        push(32'h0040a103, 32'h200);
        cycle();
        lsb_full = 1;
        cycle();
        apply_reset();
        #1;
        chk("ar_disp", 32'(disp_o), 0);
        chk("ar_cls", 32'(disp_class_o), 0);
        chk("ar_imm", disp_imm_o, 0);
        chk("ar_pc", disp_pc_o, 0);
        chk("ar_cnt", 32'(issued_cnt_o), 0);
        @(posedge clk);
        #1;
        lsb_full = 0;
        rst = 1;

        // counter wrap: 17 dispatches on a 4-bit counter
        for (int k = 0; k < 17; k++)
            push(32'h00100093, 32'(32'h300 + k * 4));
        guard = 0;
        while ((q.size() != 0 || m_dvalid) && guard < 60) begin
            cycle();
            guard++;
        end
        chk("wrap_timeout", 32'(guard < 60), 1);
        settle();
        chk("wrap_cnt", 32'(issued_cnt_o), 1);
        tick();

        // randomized traffic
        n = 0;
        for (int k = 0; k < 400; k++) begin
            if (q.size() < 8 && $urandom_range(0, 9) < 6) begin
                r = $urandom;
                push({r[31:7], ops[$urandom_range(0, 9)]}, 32'(n * 4));
                n++;
            end
            rob_full = ($urandom_range(0, 7) == 0);
            rs_full = ($urandom_range(0, 3) == 0);
            lsb_full = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 24) == 0);
            cycle();
        end
        flush = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
